ex_alu_unit: RTL and testbench
==============================

EX_ALU_UNIT -- requirements
Module: ex_alu_unit

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL: in_valid  input  1  operation request present.
REQ-004 SHALL: in_ready  output  1  unit can accept a request this cycle.
REQ-005 SHALL: alu_ctrl  input  4  operation code: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001, NOTEQ 1010, SGE 1011, SGEU 1100, JUMP 1101; all other codes are illegal.
REQ-006 SHALL: op_a  input  32  first operand (PC for JUMP).
REQ-007 SHALL: op_b  input  32  second operand; bits [4:0] form the shift amount.
REQ-008 SHALL: out_valid  output  1  registered result present.
REQ-009 SHALL: out_ready  input  1  downstream accepts the result.
REQ-010 SHALL: result  output  32  registered operation result.
REQ-011 SHALL: branch_take  output  1  registered branch condition.
REQ-012 SHALL: illegal  output  1  registered flag, set when the accepted alu_ctrl is illegal.

Function
REQ-013 SHALL: FSM states are IDLE, SHIFT and HOLD; out_valid is high only in HOLD.
REQ-014 SHALL: Define a transfer as a cycle with in_valid && in_ready.
- in_ready = (state==IDLE) || (state==HOLD && out_ready).
REQ-015 SHALL: A non-shift transfer (or a serial shift with shamt 0) loads result, branch_take and illegal, and enters HOLD on the accepting edge.
REQ-016 SHALL: Results are computed as follows.
- ADD: a+b; SUB: a-b, wrapping mod 2^32.
- SLT, SGE: signed compare, result 1 or 0.
- SLTU, SGEU: unsigned compare, result 1 or 0.
- XOR, OR, AND: bitwise.
- NOTEQ: result = (a!=b).
- JUMP: result = a+4, wrapping.
REQ-017 SHALL: branch_take is set as follows and is 0 for all other codes.
- SUB: a==b; NOTEQ: a!=b.
- SLT: a<b signed; SGE: a>=b signed.
- SLTU: a<b unsigned; SGEU: a>=b unsigned.
REQ-018 SHALL: SLL and SRL fill with zeros; SRA fills with op_a[31]; only op_b[4:0] is used.
REQ-019 SHALL: Illegal codes give result 0, branch_take 0, illegal 1, and follow single-operation latency.
REQ-020 SHALL: In HOLD, result, branch_take and illegal stay stable until out_ready is seen high.
- HOLD with out_ready and no new transfer goes to IDLE.
- HOLD with out_ready and a simultaneous transfer loads the new operation with no bubble.
REQ-021 SHALL: In SHIFT, in_ready is 0 and in_valid is ignored.
REQ-022 SHALL: A request presented while in_ready is 0 is not captured; the requester holds it.

Reset
REQ-023 SHALL: rst_n low, at any time including mid-shift or mid-HOLD, forces the following immediately and discards any in-flight operation.
- state = IDLE.
- out_valid, result, branch_take, illegal = 0.
- shift counter = 0.
REQ-024 SHALL: in_ready is 1 in the first cycle after rst_n deasserts.

Configuration
REQ-025 SHALL: Macro ALU_SERIAL_SHIFT_EN selects the shift implementation.
- Defined: shifts are serial, one bit per cycle.
  - The accepting edge loads op_a into the shift register and shamt into a 5-bit down-counter.
  - Each SHIFT edge shifts by 1 and decrements the counter.
  - The edge on which the counter reaches 0 enters HOLD.
  - out_valid therefore rises shamt edges after the accepting edge; the accepting edge itself when shamt is 0.
- Undefined: shifts use a single-cycle barrel shifter, the SHIFT state is unreachable, and all operations follow REQ-015.

Verification
REQ-026 SHALL: ADD a=0xFFFFFFFF, b=1, out_ready=1 -> result 0x00000000, branch_take 0, out_valid high for exactly 1 cycle.
REQ-027 SHALL: SLT a=0xFFFFFFFE, b=1 -> result 1, branch_take 1; SLTU with the same operands -> result 0, branch_take 0.
REQ-028 SHALL: SRA a=0x80000000, b=31, with ALU_SERIAL_SHIFT_EN defined -> in_ready low for 31 cycles, then result 0xFFFFFFFF; with the macro undefined -> same result on the next cycle.
REQ-029 SHALL: Back-to-back XOR transfers with out_ready held 0 for 3 cycles -> first result held stable, second request stalled, second result appears the cycle after out_ready rises, and no request is lost.
REQ-030 SHALL: alu_ctrl=1111 -> illegal 1, result 0; rst_n pulsed low during a 20-cycle serial shift -> all outputs 0 immediately and in_ready 1 after release.

Source files
------------

// File: rtl/ex_alu_unit.sv
// Single-issue ALU with valid/ready handshake and a registered result stage.
// Define ALU_SERIAL_SHIFT_EN to replace the barrel shifter with a one-bit-per-cycle shifter.
module ex_alu_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_ctrl,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        branch_take,
  output logic        illegal
);

  localparam logic [3:0] OpAdd   = 4'h0;
  localparam logic [3:0] OpSub   = 4'h1;
  localparam logic [3:0] OpSll   = 4'h2;
  localparam logic [3:0] OpSlt   = 4'h3;
  localparam logic [3:0] OpSltu  = 4'h4;
  localparam logic [3:0] OpXor   = 4'h5;
  localparam logic [3:0] OpSrl   = 4'h6;
  localparam logic [3:0] OpSra   = 4'h7;
  localparam logic [3:0] OpOr    = 4'h8;
  localparam logic [3:0] OpAnd   = 4'h9;
  localparam logic [3:0] OpNoteq = 4'hA;
  localparam logic [3:0] OpSge   = 4'hB;
  localparam logic [3:0] OpSgeu  = 4'hC;
  localparam logic [3:0] OpJump  = 4'hD;

  localparam logic [1:0] ShLeft  = 2'd0;
  localparam logic [1:0] ShRight = 2'd1;
  localparam logic [1:0] ShArith = 2'd2;

  typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] result_q, result_d;
  logic        branch_q, branch_d;
  logic        illegal_q, illegal_d;

  logic [4:0]  shamt;
  logic        lt_s, lt_u;
  logic [31:0] alu_res;
  logic        alu_br, alu_ill, is_shift;
  logic [1:0]  sh_type;
  logic        xfer;

  assign shamt = op_b[4:0];
  assign lt_s  = $signed(op_a) < $signed(op_b);
  assign lt_u  = op_a < op_b;

  always_comb begin
    alu_res  = '0;
    alu_br   = 1'b0;
    alu_ill  = 1'b0;
    is_shift = 1'b0;
    sh_type  = ShLeft;
    case (alu_ctrl)
      OpAdd:   alu_res = op_a + op_b;
      OpSub:   begin alu_res = op_a - op_b; alu_br = (op_a == op_b); end
      OpSll:   begin is_shift = 1'b1; sh_type = ShLeft; end
      OpSlt:   begin alu_res = {31'b0, lt_s}; alu_br = lt_s; end
      OpSltu:  begin alu_res = {31'b0, lt_u}; alu_br = lt_u; end
      OpXor:   alu_res = op_a ^ op_b;
      OpSrl:   begin is_shift = 1'b1; sh_type = ShRight; end
      OpSra:   begin is_shift = 1'b1; sh_type = ShArith; end
      OpOr:    alu_res = op_a | op_b;
      OpAnd:   alu_res = op_a & op_b;
      OpNoteq: begin alu_res = {31'b0, op_a != op_b}; alu_br = (op_a != op_b); end
      OpSge:   begin alu_res = {31'b0, !lt_s}; alu_br = !lt_s; end
      OpSgeu:  begin alu_res = {31'b0, !lt_u}; alu_br = !lt_u; end
      OpJump:  alu_res = op_a + 32'd4;
      default: alu_ill = 1'b1;
    endcase
    if (is_shift) begin
`ifdef ALU_SERIAL_SHIFT_EN
      // Zero-distance shifts complete immediately; others start from op_a in StShift.
      alu_res = op_a;
`else
      case (sh_type)
        ShLeft:  alu_res = op_a << shamt;
        ShRight: alu_res = op_a >> shamt;
        default: alu_res = $unsigned($signed(op_a) >>> shamt);
      endcase
`endif
    end
  end

`ifdef ALU_SERIAL_SHIFT_EN
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  sh_op_q, sh_op_d;
  logic [31:0] step;

  always_comb begin
    case (sh_op_q)
      ShLeft:  step = {result_q[30:0], 1'b0};
      ShRight: step = {1'b0, result_q[31:1]};
      default: step = {result_q[31], result_q[31:1]};
    endcase
  end
`endif

  assign in_ready = (state_q == StIdle) || ((state_q == StHold) && out_ready);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    branch_d  = branch_q;
    illegal_d = illegal_q;
`ifdef ALU_SERIAL_SHIFT_EN
    cnt_d     = cnt_q;
    sh_op_d   = sh_op_q;
`endif
    case (state_q)
      StHold: if (out_ready) state_d = StIdle;
`ifdef ALU_SERIAL_SHIFT_EN
      StShift: begin
        result_d = step;
        cnt_d    = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = StHold;
      end
`else
      StShift: state_d = StIdle;
`endif
      default: ;
    endcase
    if (xfer) begin
      result_d  = alu_res;
      branch_d  = alu_br;
      illegal_d = alu_ill;
      state_d   = StHold;
`ifdef ALU_SERIAL_SHIFT_EN
      if (is_shift && (shamt != 5'd0)) begin
        state_d = StShift;
        cnt_d   = shamt;
        sh_op_d = sh_type;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      result_q  <= '0;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_SERIAL_SHIFT_EN
      cnt_q     <= '0;
      sh_op_q   <= ShLeft;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      branch_q  <= branch_d;
      illegal_q <= illegal_d;
`ifdef ALU_SERIAL_SHIFT_EN
      cnt_q     <= cnt_d;
      sh_op_q   <= sh_op_d;
`endif
    end
  end

  assign out_valid   = (state_q == StHold);
  assign result      = result_q;
  assign branch_take = branch_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Self-checking bench for ex_alu_unit: expected results are queued at each accepted
// request and popped when the unit presents its output.
module tb_ex_alu_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        branch_take;
  logic        illegal;

  typedef struct packed {
    logic [31:0] res;
    logic        br;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  ex_alu_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_ctrl    (alu_ctrl),
    .op_a        (op_a),
    .op_b        (op_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .branch_take (branch_take),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: shifts by explicit bit loops, signed compare via sign bits.
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic        ult, slt;
    logic [31:0] v;
    int          sh;
    e   = '0;
    ult = (a < b);
    slt = (a[31] != b[31]) ? a[31] : ult;
    sh  = int'(b[4:0]);
    v   = a;
    case (c)
      4'h0: e.res = a + b;
      4'h1: begin e.res = a - b; e.br = (a == b); end
      4'h2: begin for (int i = 0; i < sh; i++) v = {v[30:0], 1'b0}; e.res = v; end
      4'h3: begin e.res = {31'b0, slt}; e.br = slt; end
      4'h4: begin e.res = {31'b0, ult}; e.br = ult; end
      4'h5: e.res = a ^ b;
      4'h6: begin for (int i = 0; i < sh; i++) v = {1'b0, v[31:1]}; e.res = v; end
      4'h7: begin for (int i = 0; i < sh; i++) v = {v[31], v[31:1]}; e.res = v; end
      4'h8: e.res = a | b;
      4'h9: e.res = a & b;
      4'hA: begin e.res = {31'b0, a != b}; e.br = (a != b); end
      4'hB: begin e.res = {31'b0, !slt}; e.br = !slt; end
      4'hC: begin e.res = {31'b0, !ult}; e.br = !ult; end
      4'hD: e.res = a + 32'd4;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic int latency(input logic [3:0] c, input logic [31:0] b);
`ifdef ALU_SERIAL_SHIFT_EN
    if (c == 4'h2 || c == 4'h6 || c == 4'h7) return int'(b[4:0]);
`endif
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request until accepted (bounded); returns 1 at +1 after the accepting edge.
  task automatic drive_req(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                           output bit ok);
    in_valid = 1'b1;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    ok       = 1'b0;
    #1;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (in_ready) begin
        sb.push_back(model(c, a, b));
        ok = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_ctrl  = '0;
    op_a      = '0;
    op_b      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_miss++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_vec++;
    if (out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++;
    if (result !== 32'h0) begin n_miss++; $display("FAIL reset_result got %h want 0", result); end
    n_vec++;
    if ({branch_take, illegal} !== 2'b00) begin
      n_miss++; $display("FAIL reset_flags got %b%b want 00", branch_take, illegal);
    end
    tick();
  endtask

  task automatic test_add_wrap();
    bit   ok;
    exp_t e;
    out_ready = 1'b1;
    drive_req(4'h0, 32'hFFFF_FFFF, 32'h1, ok);
    n_vec++;
    if (ok !== 1'b1) begin n_miss++; $display("FAIL add_accept got %b want 1", ok); end
    n_vec++;
    if (out_valid !== 1'b1) begin n_miss++; $display("FAIL add_valid got %b want 1", out_valid); end
    e = sb.pop_front();
    n_vec++;
    if ({result, branch_take} !== {e.res, e.br}) begin
      n_miss++; $display("FAIL add_result got %h/%b want %h/%b", result, branch_take, e.res, e.br);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin n_miss++; $display("FAIL add_valid_1cyc got %b want 0", out_valid); end
  endtask

  task automatic test_ops();
    logic [3:0]  c_t[12] = '{4'h3, 4'h4, 4'h1, 4'h1, 4'hA, 4'hB, 4'hB, 4'hC,
                             4'h5, 4'h8, 4'h9, 4'hD};
    logic [31:0] a_t[12] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h1234_5678, 32'h5, 32'h7,
                             32'h8000_0000, 32'h3, 32'hFFFF_FFFF, 32'hA5A5_0F0F,
                             32'hF000_000F, 32'hFF00_FF00, 32'hFFFF_FFFC};
    logic [31:0] b_t[12] = '{32'h1, 32'h1, 32'h1234_5678, 32'h9, 32'h7, 32'h1, 32'h3,
                             32'h1, 32'h0FF0_FFFF, 32'h0F0F_0000, 32'h0FF0_0FF0, 32'h0};
    bit   ok;
    int   n;
    exp_t e;
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      drive_req(c_t[k], a_t[k], b_t[k], ok);
      n = 0;
      while (!out_valid && n < 40) begin tick(); n++; end
      n_vec++;
      if (!(ok && out_valid)) begin
        n_miss++; $display("FAIL op%0d_handshake got ok=%b valid=%b want 1/1", k, ok, out_valid);
      end
      e = sb.pop_front();
      n_vec++;
      if ({result, branch_take, illegal} !== {e.res, e.br, e.ill}) begin
        n_miss++;
        $display("FAIL op%0d_ctrl%h got %h/%b/%b want %h/%b/%b", k, c_t[k], result, branch_take,
                 illegal, e.res, e.br, e.ill);
      end
      tick();
    end
  endtask

  task automatic test_shift();
    logic [3:0]  c_t[6] = '{4'h7, 4'h2, 4'h6, 4'h7, 4'h2, 4'h6};
    logic [31:0] a_t[6] = '{32'h8000_0000, 32'h0000_0001, 32'hF000_0000, 32'h7FFF_FFF0,
                            32'h1234_5678, 32'hABCD_EF01};
    logic [31:0] b_t[6] = '{32'd31, 32'd5, 32'd4, 32'd3, 32'd0, 32'hFFFF_FFE1};
    bit   ok;
    int   n, low;
    exp_t e;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive_req(c_t[k], a_t[k], b_t[k], ok);
      n   = 0;
      low = 0;
      while (!out_valid && n < 64) begin
        if (!in_ready) low++;
        tick();
        n++;
      end
      n_vec++;
      if (!ok || n != latency(c_t[k], b_t[k]) || low != n) begin
        n_miss++;
        $display("FAIL shift%0d_latency got %0d (ready low %0d) want %0d", k, n, low,
                 latency(c_t[k], b_t[k]));
      end
      e = sb.pop_front();
      n_vec++;
      if ({result, branch_take, illegal} !== {e.res, e.br, e.ill}) begin
        n_miss++;
        $display("FAIL shift%0d_result got %h/%b/%b want %h/%b/%b", k, result, branch_take,
                 illegal, e.res, e.br, e.ill);
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    logic [3:0] c_t[2] = '{4'hF, 4'hE};
    bit   ok;
    exp_t e;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive_req(c_t[k], $urandom, $urandom, ok);
      n_vec++;
      if (!(ok && out_valid)) begin
        n_miss++; $display("FAIL illegal%0d_valid got ok=%b valid=%b want 1/1", k, ok, out_valid);
      end
      e = sb.pop_front();
      n_vec++;
      if ({result, branch_take, illegal} !== {32'h0, 1'b0, 1'b1} ||
          {result, branch_take, illegal} !== {e.res, e.br, e.ill}) begin
        n_miss++;
        $display("FAIL illegal%0d got %h/%b/%b want 00000000/0/1", k, result, branch_take, illegal);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    bit   ok;
    exp_t e1, e2;
    out_ready = 1'b0;
    drive_req(4'h5, 32'hDEAD_BEEF, 32'h0F0F_F0F0, ok);
    e1 = sb[0];
    in_valid = 1'b1;
    alu_ctrl = 4'h5;
    op_a     = 32'h1357_9BDF;
    op_b     = 32'hFFFF_0000;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (!ok || in_ready !== 1'b0 || out_valid !== 1'b1 || result !== e1.res) begin
        n_miss++;
        $display("FAIL b2b_hold%0d got ready=%b valid=%b res=%h want 0/1/%h", i, in_ready,
                 out_valid, result, e1.res);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_miss++; $display("FAIL b2b_ready got %b want 1", in_ready); end
    sb.push_back(model(alu_ctrl, op_a, op_b));
    void'(sb.pop_front());
    tick();
    in_valid = 1'b0;
    e2 = sb.pop_front();
    n_vec++;
    if (out_valid !== 1'b1 || result !== e2.res) begin
      n_miss++;
      $display("FAIL b2b_second got valid=%b res=%h want 1/%h", out_valid, result, e2.res);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin n_miss++; $display("FAIL b2b_drain got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midop();
    bit ok;
`ifdef ALU_SERIAL_SHIFT_EN
    out_ready = 1'b1;
    drive_req(4'h2, 32'h0000_0001, 32'd20, ok);
    repeat (5) tick();
`else
    out_ready = 1'b0;
    drive_req(4'hF, 32'h1, 32'h2, ok);
    repeat (2) tick();
`endif
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    n_vec++;
    if (!ok || {out_valid, result, branch_take, illegal} !== 35'h0) begin
      n_miss++;
      $display("FAIL midreset_outputs got %b/%h/%b/%b want 0/00000000/0/0", out_valid, result,
               branch_take, illegal);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin n_miss++; $display("FAIL midreset_ready got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_miss++; $display("FAIL release_ready got %b want 1", in_ready); end
    repeat (3) tick();
    n_vec++;
    if (out_valid !== 1'b0) begin n_miss++; $display("FAIL release_idle got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_ops();
    test_shift();
    test_illegal();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
